// File: rtl/jellyvl_etherneco_packet_rx.sv
// Etherneco ring receiver: splits the returning byte stream into header fields
// (type, node, length) and a framed payload stream, flagging malformed frames.
module jellyvl_etherneco_packet_rx #(
   parameter bit CHECK_TRAILING = 1'b1
) (
   input  logic        reset,
   input  logic        clk,

   input  logic        s_rx_first,
   input  logic        s_rx_last,
   input  logic [7:0]  s_rx_data,
   input  logic        s_rx_valid,

   output logic        header_valid,
   output logic [7:0]  header_type,
   output logic [7:0]  header_node,
   output logic [15:0] header_length,

   output logic        m_first,
   output logic        m_last,
   output logic [7:0]  m_data,
   output logic        m_valid,

   output logic        frame_end,
   output logic        frame_error
);

   // state   | meaning
   // IDLE    | waiting for a byte flagged first
   // HEADER  | collecting node and length bytes (cnt = header byte index)
   // PAYLOAD | forwarding payload bytes (cnt = payload byte index)
   // DISCARD | payload complete, dropping trailing bytes until last
   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      DISCARD
   } state_t;

   state_t      state, state_next;
   logic [15:0] cnt, cnt_next;
   logic [7:0]  type_q, type_next;
   logic [7:0]  node_q, node_next;
   logic [7:0]  len_lo_q, len_lo_next;

   logic        header_valid_next;
   logic [7:0]  header_type_next;
   logic [7:0]  header_node_next;
   logic [15:0] header_length_next;
   logic        m_first_next;
   logic        m_last_next;
   logic [7:0]  m_data_next;
   logic        m_valid_next;
   logic        frame_end_next;
   logic        frame_error_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         type_q        <= '0;
         node_q        <= '0;
         len_lo_q      <= '0;
         header_valid  <= 1'b0;
         header_type   <= '0;
         header_node   <= '0;
         header_length <= '0;
         m_first       <= 1'b0;
         m_last        <= 1'b0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         frame_end     <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         type_q        <= type_next;
         node_q        <= node_next;
         len_lo_q      <= len_lo_next;
         header_valid  <= header_valid_next;
         header_type   <= header_type_next;
         header_node   <= header_node_next;
         header_length <= header_length_next;
         m_first       <= m_first_next;
         m_last        <= m_last_next;
         m_data        <= m_data_next;
         m_valid       <= m_valid_next;
         frame_end     <= frame_end_next;
         frame_error   <= frame_error_next;
      end
   end

   always_comb begin
      state_next         = state;
      cnt_next           = cnt;
      type_next          = type_q;
      node_next          = node_q;
      len_lo_next        = len_lo_q;
      header_valid_next  = 1'b0;
      header_type_next   = header_type;
      header_node_next   = header_node;
      header_length_next = header_length;
      m_first_next       = 1'b0;
      m_last_next        = 1'b0;
      m_data_next        = m_data;
      m_valid_next       = 1'b0;
      frame_end_next     = 1'b0;
      frame_error_next   = 1'b0;

      if (s_rx_valid) begin
         if (state != IDLE && s_rx_first) begin
            // abort the running frame; the pulse belongs to the old frame only
            frame_end_next   = 1'b1;
            frame_error_next = 1'b1;
            type_next        = s_rx_data;
            if (s_rx_last) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               state_next = HEADER;
               cnt_next   = 16'd1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (s_rx_first) begin
                     type_next = s_rx_data;
                     if (s_rx_last) begin
                        frame_end_next   = 1'b1;
                        frame_error_next = 1'b1;
                     end else begin
                        state_next = HEADER;
                        cnt_next   = 16'd1;
                     end
                  end
               end

               HEADER: begin
                  if (s_rx_last) begin
                     // header incomplete or no payload at all
                     frame_end_next   = 1'b1;
                     frame_error_next = 1'b1;
                     state_next       = IDLE;
                     cnt_next         = '0;
                  end else if (cnt == 16'd1) begin
                     node_next = s_rx_data;
                     cnt_next  = 16'd2;
                  end else if (cnt == 16'd2) begin
                     len_lo_next = s_rx_data;
                     cnt_next    = 16'd3;
                  end else begin
                     header_valid_next  = 1'b1;
                     header_type_next   = type_q;
                     header_node_next   = node_q;
                     header_length_next = {s_rx_data, len_lo_q};
                     state_next         = PAYLOAD;
                     cnt_next           = '0;
                  end
               end

               PAYLOAD: begin
                  m_valid_next = 1'b1;
                  m_data_next  = s_rx_data;
                  m_first_next = (cnt == 16'd0);
                  if (cnt == header_length) begin
                     m_last_next = 1'b1;
                     cnt_next    = '0;
                     if (s_rx_last) begin
                        frame_end_next = 1'b1;
                        state_next     = IDLE;
                     end else begin
                        state_next = DISCARD;
                     end
                  end else if (s_rx_last) begin
                     m_last_next      = 1'b1;
                     frame_end_next   = 1'b1;
                     frame_error_next = 1'b1;
                     state_next       = IDLE;
                     cnt_next         = '0;
                  end else begin
                     cnt_next = cnt + 16'd1;
                  end
               end

               DISCARD: begin
                  if (s_rx_last) begin
                     frame_end_next   = 1'b1;
                     frame_error_next = CHECK_TRAILING;
                     state_next       = IDLE;
                  end
               end

               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx.sv
// Bench for jellyvl_etherneco_packet_rx: directed byte vectors with hand-computed
// outputs, run on two instances (trailing bytes flagged / dropped).
module tb_jellyvl_etherneco_packet_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_rx_first, s_rx_last, s_rx_valid;
   logic [7:0]  s_rx_data;

   logic        header_valid, m_first, m_last, m_valid, frame_end, frame_error;
   logic [7:0]  header_type, header_node, m_data;
   logic [15:0] header_length;

   logic        header_valid0, m_first0, m_last0, m_valid0, frame_end0, frame_error0;
   logic [7:0]  header_type0, header_node0, m_data0;
   logic [15:0] header_length0;

   always #5 clk = ~clk;

   jellyvl_etherneco_packet_rx #(.CHECK_TRAILING(1'b1)) dut (
      .reset(reset), .clk(clk),
      .s_rx_first(s_rx_first), .s_rx_last(s_rx_last), .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
      .header_valid(header_valid), .header_type(header_type), .header_node(header_node),
      .header_length(header_length),
      .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid),
      .frame_end(frame_end), .frame_error(frame_error)
   );

   jellyvl_etherneco_packet_rx #(.CHECK_TRAILING(1'b0)) dut0 (
      .reset(reset), .clk(clk),
      .s_rx_first(s_rx_first), .s_rx_last(s_rx_last), .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
      .header_valid(header_valid0), .header_type(header_type0), .header_node(header_node0),
      .header_length(header_length0),
      .m_first(m_first0), .m_last(m_last0), .m_data(m_data0), .m_valid(m_valid0),
      .frame_end(frame_end0), .frame_error(frame_error0)
   );

   typedef struct {
      logic        rst;
      logic        first;
      logic        last;
      logic        valid;
      logic [7:0]  data;
      logic [13:0] exp_out;   // {hv, mv, mf, ml, md, fe, fer}
      logic        exp_err0;  // frame_error expected when trailing bytes are dropped
      logic [31:0] exp_hdr;   // {type, node, length}
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   int          nstep  = 0;
   bit          live   = 1'b0;
   logic [7:0]  eh_type = 8'h00;
   logic [7:0]  eh_node = 8'h00;
   logic [15:0] eh_len  = 16'h0000;

   function automatic vec_t mk(input logic rst, f, l, v, input logic [7:0] d,
                               input logic hv, mv, mf, ml, input logic [7:0] md,
                               input logic fe, fer, fer0);
      vec_t r;
      r.rst      = rst;
      r.first    = f;
      r.last     = l;
      r.valid    = v;
      r.data     = d;
      r.exp_out  = {hv, mv, mf, ml, (mv ? md : 8'h00), fe, fer};
      r.exp_err0 = fer0;
      r.exp_hdr  = {eh_type, eh_node, eh_len};
      return r;
   endfunction

   function automatic vec_t z(input logic f, l, v, input logic [7:0] d);
      return mk(1'b0, f, l, v, d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic vec_t pay(input logic [7:0] d, input logic l, mf, ml, fe, fer, fer0);
      return mk(1'b0, 1'b0, l, 1'b1, d, 1'b0, 1'b1, mf, ml, d, fe, fer, fer0);
   endfunction

   task automatic step(input vec_t v);
      logic [13:0] act, act0;
      logic [31:0] hdr;
      reset      = v.rst;
      s_rx_first = v.first;
      s_rx_last  = v.last;
      s_rx_valid = v.valid;
      s_rx_data  = v.data;
      @(posedge clk);
      #1;
      act  = {header_valid, m_valid, m_first, m_last, (m_valid ? m_data : 8'h00), frame_end, frame_error};
      act0 = {header_valid0, m_valid0, m_first0, m_last0, (m_valid0 ? m_data0 : 8'h00), frame_end0, frame_error0};
      hdr  = {header_type, header_node, header_length};
      checks += 3;
      if (act !== v.exp_out) begin
         errors++;
         $display("FAIL step%0d outputs {hv,mv,mf,ml,md,fe,fer}: got %b required %b", nstep, act, v.exp_out);
      end
      if (act0 !== {v.exp_out[13:1], v.exp_err0}) begin
         errors++;
         $display("FAIL step%0d outputs_no_trailing_check: got %b required %b",
                  nstep, act0, {v.exp_out[13:1], v.exp_err0});
      end
      if (hdr !== v.exp_hdr) begin
         errors++;
         $display("FAIL step%0d header {type,node,length}: got %h required %h", nstep, hdr, v.exp_hdr);
      end
      nstep++;
   endtask

   task automatic put(input vec_t v);
      if (live) step(v);
      else vecs.push_back(v);
   endtask

   task automatic hdr_rest(input logic [7:0] t, n, input logic [15:0] len);
      put(z(1'b0, 1'b0, 1'b1, n));
      put(z(1'b0, 1'b0, 1'b1, len[7:0]));
      eh_type = t;
      eh_node = n;
      eh_len  = len;
      put(mk(1'b0, 1'b0, 1'b0, 1'b1, len[15:8], 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic hdr(input logic [7:0] t, n, input logic [15:0] len);
      put(z(1'b1, 1'b0, 1'b1, t));
      hdr_rest(t, n, len);
   endtask

   initial begin
      reset = 1'b1; s_rx_first = 1'b0; s_rx_last = 1'b0; s_rx_valid = 1'b0; s_rx_data = 8'h00;

      // reset state, including a valid first byte that reset must override
      put(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      put(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hAB, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      put(z(1'b0, 1'b0, 1'b0, 8'h00));

      // good frame: 13 payload bytes
      hdr(8'h10, 8'h00, 16'h000C);
      for (int i = 0; i <= 12; i++)
         put(pay(8'(i), i == 12, i == 0, i == 12, i == 12, 1'b0, 1'b0));

      // truncated on payload byte 5
      hdr(8'h10, 8'h00, 16'h000C);
      for (int i = 0; i <= 5; i++)
         put(pay(8'(i), i == 5, i == 0, i == 5, i == 5, i == 5, i == 5));

      // overrun: two expected payload bytes, four sent
      hdr(8'h20, 8'h03, 16'h0001);
      put(pay(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      put(pay(8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      put(z(1'b0, 1'b0, 1'b1, 8'hCC));
      put(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'hDD, 0, 0, 0, 0, 8'h00, 1, 1, 0));

      // single-byte frame
      put(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 0, 0, 0, 0, 8'h00, 1, 1, 1));

      // idle: valid without first, and first without valid, both ignored
      put(z(1'b0, 1'b0, 1'b1, 8'h55));
      put(z(1'b1, 1'b0, 1'b0, 8'h77));

      // abort after 3 payload bytes; the aborting byte starts the next frame
      hdr(8'h10, 8'h00, 16'h000C);
      for (int i = 0; i < 3; i++)
         put(pay(8'(i), 1'b0, i == 0, 1'b0, 1'b0, 1'b0, 1'b0));
      put(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 0, 0, 0, 0, 8'h00, 1, 1, 1));
      hdr_rest(8'h30, 8'h05, 16'h0002);
      put(pay(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      put(pay(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      put(pay(8'h09, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

      // valid gaps throughout a good frame
      put(z(1'b1, 1'b0, 1'b1, 8'h40));
      put(z(1'b1, 1'b1, 1'b0, 8'hEE));
      put(z(1'b0, 1'b0, 1'b1, 8'h01));
      put(z(1'b0, 1'b0, 1'b0, 8'hEE));
      put(z(1'b0, 1'b0, 1'b1, 8'h01));
      eh_type = 8'h40; eh_node = 8'h01; eh_len = 16'h0001;
      put(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
      put(z(1'b1, 1'b1, 1'b0, 8'hEE));
      put(pay(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      put(z(1'b0, 1'b1, 1'b0, 8'hEE));
      put(z(1'b0, 1'b0, 1'b0, 8'hEE));
      put(pay(8'hE1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

      // header truncated on node byte: previous header fields retained
      put(z(1'b1, 1'b0, 1'b1, 8'h50));
      put(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 0, 0, 0, 0, 8'h00, 1, 1, 1));
      put(z(1'b0, 1'b0, 1'b0, 8'h00));

      foreach (vecs[i]) step(vecs[i]);

      live = 1'b1;

      // reset mid-payload, then bytes without first are ignored, then recovery
      hdr(8'h60, 8'h01, 16'h0004);
      put(pay(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      put(pay(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      eh_type = 8'h00; eh_node = 8'h00; eh_len = 16'h0000;
      put(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      put(z(1'b0, 1'b0, 1'b1, 8'h03));
      put(z(1'b0, 1'b1, 1'b1, 8'h04));
      hdr(8'h61, 8'h02, 16'h0000);
      put(pay(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

      // abort while discarding trailing bytes
      hdr(8'h70, 8'h02, 16'h0000);
      put(pay(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      put(z(1'b0, 1'b0, 1'b1, 8'h12));
      put(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h71, 0, 0, 0, 0, 8'h00, 1, 1, 1));
      hdr_rest(8'h71, 8'h02, 16'h0000);
      put(pay(8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
